// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// The state encodings match the original localparam values.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-counter width for a given operand width (operands are at least 2 bits).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_addsub_fadd.sv
// One-bit full adder cell; the serial datapath's single bit slice.
module Fadd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock,
// with a start/busy/done handshake around a single Fadd cell.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic             busy_nx;
    logic             done_nx;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    // Only the upper WIDTH-1 result bits are stored; the last sum bit
    // goes straight into the output register on the final edge.
    logic [WIDTH-2:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             sum_cell;
    logic             cout_cell;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == ST_IDLE) && start;
    assign last_bit = (state == ST_RUN) && (cnt == LAST);

    Fadd u_fadd (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .cout (cout_cell),
        .sum  (sum_cell)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // busy/done are registered from the current state, so they trail it by one edge.
    always_comb begin
        busy_nx = (state == ST_RUN) || (state == ST_DONE);
        done_nx = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res   <= (res >> 1) | ((WIDTH-1)'(sum_cell) << (WIDTH - 2));
            carry <= cout_cell;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= {sum_cell, res};
                cout <= cout_cell;
                ovf  <= carry ^ cout_cell;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: WIDTH=8 directed/random cases plus
// an exhaustive back-to-back WIDTH=4 sweep against an arithmetic reference.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    logic       start4, sub4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .sub   (sub8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .sub   (sub4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .ovf   (ovf4)
    );

    // Reference: unsigned sum for result/carry, signed integer range for overflow.
    function automatic void model(input int w, input int ua, input int ub, input bit s,
                                  output int rs, output bit rc, output bit rv);
        int mask;
        int full;
        int sa;
        int sb;
        int sr;
        mask = (1 << w) - 1;
        full = s ? (ua + ((~ub) & mask) + 1) : (ua + ub);
        rs   = full & mask;
        rc   = ((full >> w) & 1) != 0;
        sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        sr   = s ? sa - sb : sa + sb;
        rv   = (sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1)));
    endfunction

    // Drives one WIDTH=8 op; lat = edges after acceptance until done seen (-1 on timeout).
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                        output int lat, output int bc);
        lat = -1;
        bc  = 0;
        @(negedge clk);
        a8 = ta; b8 = tb_; sub8 = ts; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (busy8) bc++;
            if (done8 && lat < 0) lat = i;
            if (lat >= 0 && !done8) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0;
        start4 = 1'b1; a4 = 4'hF;  b4 = 4'h1;  sub4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all zero",
                     busy8, done8, sum8, cout8, ovf8);
        end
        checks++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 8'h00) begin
            failures++;
            $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all zero",
                     busy4, done4, sum4, cout4, ovf4);
        end
        @(negedge clk);
        start8 = 1'b0; start4 = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int lat, bc, rs;
        bit rc, rv;
        run8(8'h0F, 8'h01, 1'b0, lat, bc);
        model(8, 'h0F, 'h01, 1'b0, rs, rc, rv);
        checks++;
        if (lat != 9) begin
            failures++;
            $display("FAIL latency: got %0d edges expected 9", lat);
        end
        checks++;
        if (bc != 9) begin
            failures++;
            $display("FAIL busy_len: got %0d cycles expected 9", bc);
        end
        checks++;
        if ({sum8, cout8, ovf8} !== {8'(rs), rc, rv}) begin
            failures++;
            $display("FAIL add_0f_01: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     sum8, cout8, ovf8, 8'(rs), rc, rv);
        end
    endtask

    task automatic test_arith(input bit s);
        logic [7:0] va [0:9];
        logic [7:0] vb [0:9];
        int lat, bc, rs;
        bit rc, rv;
        if (!s) begin
            va[0] = 8'hFF; vb[0] = 8'h01;
            va[1] = 8'h7F; vb[1] = 8'h01;
        end else begin
            va[0] = 8'h05; vb[0] = 8'h07;
            va[1] = 8'h80; vb[1] = 8'h01;
        end
        for (int i = 2; i < 10; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
        end
        for (int i = 0; i < 10; i++) begin
            run8(va[i], vb[i], s, lat, bc);
            model(8, int'(va[i]), int'(vb[i]), s, rs, rc, rv);
            checks++;
            if (lat != 9) begin
                failures++;
                $display("FAIL arith_latency sub=%0b a=%h b=%h: got %0d expected 9",
                         s, va[i], vb[i], lat);
            end
            checks++;
            if ({sum8, cout8, ovf8} !== {8'(rs), rc, rv}) begin
                failures++;
                $display("FAIL arith sub=%0b a=%h b=%h: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                         s, va[i], vb[i], sum8, cout8, ovf8, 8'(rs), rc, rv);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        dones = 0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            start8 = (i == 2);
            a8     = (i == 2) ? 8'hAA : 8'h00;
            b8     = (i == 2) ? 8'h55 : 8'h00;
            if (done8) begin
                dones++;
                checks++;
                if (sum8 !== 8'h30) begin
                    failures++;
                    $display("FAIL ignore_sum: got %h expected 30", sum8);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL ignore_dones: got %0d expected 1", dones);
        end
        checks++;
        if (sum8 !== 8'h30 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL ignore_hold: got sum=%h busy=%b expected sum=30 busy=0", sum8, busy8);
        end
    endtask

    task automatic test_reset_midop();
        int lat, bc, rs, dones;
        bit rc, rv;
        run8(8'h80, 8'h01, 1'b1, lat, bc);
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h5A; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all zero",
                     busy8, done8, sum8, cout8, ovf8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midop_quiet: got %0d busy/done cycles expected 0", dones);
        end
        run8(8'hC8, 8'h64, 1'b0, lat, bc);
        model(8, 'hC8, 'h64, 1'b0, rs, rc, rv);
        checks++;
        if (lat != 9 || {sum8, cout8, ovf8} !== {8'(rs), rc, rv}) begin
            failures++;
            $display("FAIL midop_recover: got lat=%0d sum=%h cout=%b ovf=%b expected lat=9 sum=%h cout=%b ovf=%b",
                     lat, sum8, cout8, ovf8, 8'(rs), rc, rv);
        end
    endtask

    task automatic test_sweep4();
        int idx, got, cycles, last_done, rs;
        bit rc, rv;
        idx = 0; got = 0; cycles = 0; last_done = 0;
        @(negedge clk);
        a4 = 4'(idx >> 4); b4 = 4'(idx); sub4 = 1'(idx >> 8); start4 = 1'b1;
        idx++;
        while (got < 512 && cycles < 6000) begin
            @(negedge clk);
            cycles++;
            start4 = 1'b0;
            if (done4) begin
                model(4, (got >> 4) & 15, got & 15, ((got >> 8) & 1) != 0, rs, rc, rv);
                checks++;
                if ({sum4, cout4, ovf4} !== {4'(rs), rc, rv}) begin
                    failures++;
                    $display("FAIL sweep4 op=%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                             got, sum4, cout4, ovf4, 4'(rs), rc, rv);
                end
                if (got > 0) begin
                    checks++;
                    if (cycles - last_done != 6) begin
                        failures++;
                        $display("FAIL sweep4_period op=%0d: got %0d cycles expected 6",
                                 got, cycles - last_done);
                    end
                end
                last_done = cycles;
                got++;
                if (idx < 512) begin
                    a4 = 4'(idx >> 4); b4 = 4'(idx); sub4 = 1'(idx >> 8); start4 = 1'b1;
                    idx++;
                end
            end
        end
        checks++;
        if (got != 512) begin
            failures++;
            $display("FAIL sweep4_timeout: got %0d results expected 512", got);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith(1'b0);
        test_arith(1'b1);
        test_ignore_start();
        test_reset_midop();
        test_sweep4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
